// File: rtl/long_op_scoreboard_pkg.sv
// Shared register-file geometry and decode helpers for the long-op scoreboard.
// Pure declarations; no logic.
package core_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NREG      = 32;

   // Bit positions inside the ID-stage ftype field
   localparam int FTYPE_RS1 = 0;
   localparam int FTYPE_RS2 = 1;

   function automatic logic [NREG-1:0] onehot32(input logic [REG_IDX_W-1:0] idx);
      logic [NREG-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/long_op_scoreboard_bank.sv
// One 32-entry pending bitmap: set on issue, clear on writeback, lookup of three indices
// against the post-clear view. Hits are combinational; bitmap updates land on the next edge.
module scoreboard_bank
   import core_pkg::*;
#(
   parameter bit HARD_X0 = 1'b0
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en_i,
   input  logic [REG_IDX_W-1:0] set_idx_i,
   input  logic                 clr_en_i,
   input  logic [REG_IDX_W-1:0] clr_idx_i,
   input  logic [REG_IDX_W-1:0] rs1_idx_i,
   input  logic [REG_IDX_W-1:0] rs2_idx_i,
   input  logic [REG_IDX_W-1:0] rd_idx_i,
   output logic                 rs1_hit_o,
   output logic                 rs2_hit_o,
   output logic                 rd_hit_o,
   output logic [NREG-1:0]      busy_o
);

   // Entry 0 of a hardwired-zero file can never be set, cleared or hit
   localparam logic [NREG-1:0] LIVE_MASK =
      HARD_X0 ? {{(NREG-1){1'b1}}, 1'b0} : {NREG{1'b1}};

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] eff_busy;

   always_comb begin
      set_vec  = set_en_i ? (onehot32(set_idx_i) & LIVE_MASK) : '0;
      clr_vec  = clr_en_i ? (onehot32(clr_idx_i) & LIVE_MASK) : '0;
      eff_busy = busy_q & ~clr_vec;
      // Set applied after clear: a same-cycle retire/re-issue leaves the entry owned
      busy_d   = eff_busy | set_vec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_hit_o = eff_busy[rs1_idx_i];
   assign rs2_hit_o = eff_busy[rs2_idx_i];
   assign rd_hit_o  = eff_busy[rd_idx_i];
   assign busy_o    = busy_q;

endmodule

// File: rtl/long_op_scoreboard.sv
// Tracks int/FP destinations of in-flight long-latency ops and stalls ID on RAW/WAW/limit hazards.
// Stall is combinational (zero latency); busy bits and count update one edge after issue/writeback.
module long_op_scoreboard
   import core_pkg::*;
#(
   parameter int MAX_PEND = 4,
   parameter int CNT_W    = 3
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] i_D_rs1_index,
   input  logic [REG_IDX_W-1:0] i_D_rs2_index,
   input  logic [1:0]           i_D_ftype,
   input  logic [REG_IDX_W-1:0] i_D_rd_index,
   input  logic                 i_D_wb_en,
   input  logic                 i_D_wb_en_f,
   input  logic                 i_D_long,
   input  logic                 i_D_valid,
   input  logic                 i_flush,
   input  logic [REG_IDX_W-1:0] i_W_rd_index,
   input  logic                 i_W_wb_en,
   input  logic                 i_W_wb_en_f,
   input  logic                 i_W_long_done,
   output logic                 o_stall,
   output logic [NREG-1:0]      o_busy_x,
   output logic [NREG-1:0]      o_busy_f,
   output logic [CNT_W-1:0]     o_pend_cnt,
   output logic                 o_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

   logic             x_rs1_hit, x_rs2_hit, x_rd_hit;
   logic             f_rs1_hit, f_rs2_hit, f_rd_hit;
   logic             raw_rs1, raw_rs2, waw, full;
   logic             id_live, issue;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   scoreboard_bank #(.HARD_X0(1'b1)) u_bank_x (
      .clk       (clk),
      .rst       (rst),
      .set_en_i  (issue & i_D_wb_en),
      .set_idx_i (i_D_rd_index),
      .clr_en_i  (i_W_long_done & i_W_wb_en),
      .clr_idx_i (i_W_rd_index),
      .rs1_idx_i (i_D_rs1_index),
      .rs2_idx_i (i_D_rs2_index),
      .rd_idx_i  (i_D_rd_index),
      .rs1_hit_o (x_rs1_hit),
      .rs2_hit_o (x_rs2_hit),
      .rd_hit_o  (x_rd_hit),
      .busy_o    (o_busy_x)
   );

   scoreboard_bank #(.HARD_X0(1'b0)) u_bank_f (
      .clk       (clk),
      .rst       (rst),
      .set_en_i  (issue & i_D_wb_en_f),
      .set_idx_i (i_D_rd_index),
      .clr_en_i  (i_W_long_done & i_W_wb_en_f),
      .clr_idx_i (i_W_rd_index),
      .rs1_idx_i (i_D_rs1_index),
      .rs2_idx_i (i_D_rs2_index),
      .rd_idx_i  (i_D_rd_index),
      .rs1_hit_o (f_rs1_hit),
      .rs2_hit_o (f_rs2_hit),
      .rd_hit_o  (f_rd_hit),
      .busy_o    (o_busy_f)
   );

   always_comb begin
      raw_rs1 = i_D_ftype[FTYPE_RS1] ? f_rs1_hit : x_rs1_hit;
      raw_rs2 = i_D_ftype[FTYPE_RS2] ? f_rs2_hit : x_rs2_hit;
      waw     = (i_D_wb_en & x_rd_hit) | (i_D_wb_en_f & f_rd_hit);
      // A retiring long op frees a slot in the same cycle
      full    = i_D_long & (cnt_q == CNT_MAX) & ~i_W_long_done;
      id_live = i_D_valid & ~i_flush;
      o_stall = id_live & (raw_rs1 | raw_rs2 | waw | full);
      issue   = id_live & ~o_stall & i_D_long;
   end

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (issue && !i_W_long_done) begin
         if (cnt_q == CNT_MAX) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (i_W_long_done && !issue) begin
         if (cnt_q == '0) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign o_pend_cnt = cnt_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_long_op_scoreboard.sv
// Directed vector table plus hand sequences for the long-op scoreboard.
module tb_long_op_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd, wrd;
   logic [1:0]  ftype;
   logic        wb, wbf, lng, vld, fl, wwb, wwbf, wdn;
   logic        stall;
   logic [31:0] busy_x, busy_f;
   logic [2:0]  pend_cnt;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   long_op_scoreboard #(.MAX_PEND(4), .CNT_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_D_rs1_index (rs1),
      .i_D_rs2_index (rs2),
      .i_D_ftype     (ftype),
      .i_D_rd_index  (rd),
      .i_D_wb_en     (wb),
      .i_D_wb_en_f   (wbf),
      .i_D_long      (lng),
      .i_D_valid     (vld),
      .i_flush       (fl),
      .i_W_rd_index  (wrd),
      .i_W_wb_en     (wwb),
      .i_W_wb_en_f   (wwbf),
      .i_W_long_done (wdn),
      .o_stall       (stall),
      .o_busy_x      (busy_x),
      .o_busy_f      (busy_f),
      .o_pend_cnt    (pend_cnt),
      .o_err         (err)
   );

   typedef struct {
      logic        rst;
      logic        vld, fl, lng;
      logic [4:0]  rd;
      logic        wb, wbf;
      logic [4:0]  rs1, rs2;
      logic [1:0]  ft;
      logic        wdn;
      logic [4:0]  wrd;
      logic        wwb, wwbf;
      logic        e_stall;
      logic [31:0] e_bx, e_bf;
      logic [2:0]  e_cnt;
      logic        e_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic r,
      input logic v, input logic f, input logic l,
      input logic [4:0] d, input logic w, input logic wf,
      input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] t,
      input logic dn, input logic [4:0] wd, input logic ww, input logic wwf,
      input logic es, input logic [31:0] ebx, input logic [31:0] ebf,
      input logic [2:0] ec, input logic ee);
      vec_t x;
      x.rst = r; x.vld = v; x.fl = f; x.lng = l;
      x.rd = d; x.wb = w; x.wbf = wf;
      x.rs1 = s1; x.rs2 = s2; x.ft = t;
      x.wdn = dn; x.wrd = wd; x.wwb = ww; x.wwbf = wwf;
      x.e_stall = es; x.e_bx = ebx; x.e_bf = ebf; x.e_cnt = ec; x.e_err = ee;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t x);
      rst = x.rst; vld = x.vld; fl = x.fl; lng = x.lng;
      rd = x.rd; wb = x.wb; wbf = x.wbf;
      rs1 = x.rs1; rs2 = x.rs2; ftype = x.ft;
      wdn = x.wdn; wrd = x.wrd; wwb = x.wwb; wwbf = x.wwbf;
   endtask

   task automatic idle();
      drive(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 0,0,0,0, 0, 0,0,0,0));
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk); #1;

      // reset
      vq.push_back(mk(1, 0,0,0, 0,0,0, 0,0,2'b00, 0,0,0,0, 0, 32'h0,32'h0,0,0));
      // load-use on x5
      vq.push_back(mk(0, 1,0,1, 5,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h20,32'h0,1,0));
      vq.push_back(mk(0, 1,0,0, 1,1,0, 5,0,2'b00, 0,0,0,0, 1, 32'h20,32'h0,1,0));
      vq.push_back(mk(0, 1,0,0, 1,1,0, 5,0,2'b00, 0,0,0,0, 1, 32'h20,32'h0,1,0));
      vq.push_back(mk(0, 1,0,0, 1,1,0, 5,0,2'b00, 1,5,1,0, 0, 32'h0,32'h0,0,0));
      // domain isolation: f5 pending
      vq.push_back(mk(0, 1,0,1, 5,0,1, 1,2,2'b11, 0,0,0,0, 0, 32'h0,32'h20,1,0));
      vq.push_back(mk(0, 1,0,0, 3,1,0, 5,0,2'b00, 0,0,0,0, 0, 32'h0,32'h20,1,0));
      vq.push_back(mk(0, 1,0,0, 3,1,0, 0,5,2'b10, 0,0,0,0, 1, 32'h0,32'h20,1,0));
      vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 1,5,0,1, 0, 32'h0,32'h0,0,0));
      // long op to x0: counted, no busy bit
      vq.push_back(mk(0, 1,0,1, 0,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h0,32'h0,1,0));
      vq.push_back(mk(0, 1,0,0, 0,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h0,32'h0,1,0));
      vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 1,0,1,0, 0, 32'h0,32'h0,0,0));
      // fill to the limit
      vq.push_back(mk(0, 1,0,1, 1,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h02,32'h0,1,0));
      vq.push_back(mk(0, 1,0,1, 2,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h06,32'h0,2,0));
      vq.push_back(mk(0, 1,0,1, 3,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h0E,32'h0,3,0));
      vq.push_back(mk(0, 1,0,1, 4,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h1E,32'h0,4,0));
      vq.push_back(mk(0, 1,0,1, 6,1,0, 0,0,2'b00, 0,0,0,0, 1, 32'h1E,32'h0,4,0));
      vq.push_back(mk(0, 1,0,1, 6,1,0, 0,0,2'b00, 1,1,1,0, 0, 32'h5C,32'h0,4,0));
      // retire and re-issue x7 in one cycle
      vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 1,2,1,0, 0, 32'h58,32'h0,3,0));
      vq.push_back(mk(0, 1,0,1, 7,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'hD8,32'h0,4,0));
      vq.push_back(mk(0, 1,0,1, 7,1,0, 0,0,2'b00, 1,7,1,0, 0, 32'hD8,32'h0,4,0));
      // flushed reader of a busy reg: no stall, no issue
      vq.push_back(mk(0, 1,1,1, 9,1,0, 3,0,2'b00, 0,0,0,0, 0, 32'hD8,32'h0,4,0));
      // reset mid-flight with count 3, overriding a same-cycle issue
      vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 1,3,1,0, 0, 32'hD0,32'h0,3,0));
      vq.push_back(mk(1, 1,0,1, 9,1,0, 0,0,2'b00, 0,0,0,0, 0, 32'h0,32'h0,0,0));
      // underflow error, sticky
      vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 1,4,1,0, 0, 32'h0,32'h0,0,1));
      vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 0,0,0,0, 0, 32'h0,32'h0,0,1));
      // FP WAW, then dual-file clear
      vq.push_back(mk(0, 1,0,1, 8,0,1, 0,0,2'b00, 0,0,0,0, 0, 32'h0,32'h100,1,1));
      vq.push_back(mk(0, 1,0,0, 8,0,1, 0,0,2'b00, 0,0,0,0, 1, 32'h0,32'h100,1,1));
      vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0,2'b00, 1,8,1,1, 0, 32'h0,32'h0,0,1));
      vq.push_back(mk(1, 0,0,0, 0,0,0, 0,0,2'b00, 0,0,0,0, 0, 32'h0,32'h0,0,0));

      foreach (vq[i]) begin
         drive(vq[i]);
         @(negedge clk);
         chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vq[i].e_stall});
         @(posedge clk); #1;
         chk($sformatf("v%0d busy_x", i), busy_x, vq[i].e_bx);
         chk($sformatf("v%0d busy_f", i), busy_f, vq[i].e_bf);
         chk($sformatf("v%0d cnt", i), {29'b0, pend_cnt}, {29'b0, vq[i].e_cnt});
         chk($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vq[i].e_err});
      end

      // Load-use on x10: stall held for a bounded number of cycles, then released by W
      drive(mk(0, 1,0,1, 10,1,0, 0,0,2'b00, 0,0,0,0, 0, 0,0,0,0));
      @(posedge clk); #1;
      chk("lu busy_x", busy_x, 32'h400);
      drive(mk(0, 1,0,0, 11,1,0, 10,10,2'b00, 0,0,0,0, 0, 0,0,0,0));
      for (int c = 0; c < 6; c++) begin
         if (c == 5) begin
            wdn = 1'b1; wrd = 5'd10; wwb = 1'b1;
         end
         @(negedge clk);
         chk($sformatf("lu stall c%0d", c), {31'b0, stall}, (c == 5) ? 32'd0 : 32'd1);
         @(posedge clk); #1;
      end
      chk("lu busy_x clr", busy_x, 32'h0);
      chk("lu cnt", {29'b0, pend_cnt}, 32'd0);

      // FP register 0 is a real register: it can be pending and stall an FP reader
      drive(mk(0, 1,0,1, 0,0,1, 0,0,2'b00, 0,0,0,0, 0, 0,0,0,0));
      @(posedge clk); #1;
      chk("f0 busy_f", busy_f, 32'h1);
      drive(mk(0, 1,0,0, 2,1,0, 0,0,2'b00, 0,0,0,0, 0, 0,0,0,0));
      @(negedge clk);
      chk("f0 int reader", {31'b0, stall}, 32'd0);
      ftype = 2'b01;
      #1;
      chk("f0 fp reader", {31'b0, stall}, 32'd1);
      idle();
      wdn = 1'b1; wrd = 5'd0; wwbf = 1'b1;
      @(posedge clk); #1;
      chk("f0 busy_f clr", busy_f, 32'h0);
      chk("f0 err", {31'b0, err}, 32'd0);
      idle();
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "watchdog");
   end

endmodule
